// File: rtl/fyp_rx_monitor.sv
// Avalon-ST receive monitor: frame length, error, runt/long and protocol statistics.
// Define FYP_RX_SEQ_CHECK_EN to add sequence-number checking on beat 4 of each frame.
`timescale 1ns/1ps
module fyp_rx_monitor #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  input  logic        rx_sop,
  input  logic        rx_eop,
  input  logic [1:0]  rx_empty,
  input  logic [5:0]  rx_err,
  output logic        rx_ready,
  input  logic        clr_stats,
  output logic        frame_done,
  output logic [15:0] last_len,
  output logic [31:0] frame_cnt,
  output logic [31:0] byte_cnt,
  output logic [31:0] err_cnt,
  output logic [31:0] runt_cnt,
  output logic [31:0] long_cnt,
  output logic [31:0] proto_cnt,
  output logic [31:0] seq_err_cnt
);

  typedef enum logic {IDLE, IN_FRAME} state_t;

  localparam logic [16:0] MIN_L = 17'(MIN_LEN);
  localparam logic [16:0] MAX_L = 17'(MAX_LEN);

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  state_t      state_q, state_d;
  logic        rx_ready_q, rx_ready_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] len_q, len_d;
  logic [15:0] last_len_q, last_len_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;
  logic [31:0] runt_cnt_q, runt_cnt_d;
  logic [31:0] long_cnt_q, long_cnt_d;
  logic [31:0] proto_cnt_q, proto_cnt_d;

  logic        accept;
  logic        complete;
  logic        proto_evt;
  logic [2:0]  add_bytes;
  logic [15:0] base_len;
  logic [16:0] sum_len;
  logic [15:0] new_len;

  assign accept    = rx_valid && rx_ready_q;
  assign add_bytes = rx_eop ? (3'd4 - {1'b0, rx_empty}) : 3'd4;
  // A sop beat always restarts the count, even when it abandons a frame in progress.
  assign base_len  = rx_sop ? 16'd0 : len_q;
  assign sum_len   = {1'b0, base_len} + {14'd0, add_bytes};
  assign new_len   = sum_len[16] ? 16'hFFFF : sum_len[15:0];

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    rx_ready_d   = 1'b1;
    frame_done_d = 1'b0;
    last_len_d   = last_len_q;
    frame_cnt_d  = frame_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    err_cnt_d    = err_cnt_q;
    runt_cnt_d   = runt_cnt_q;
    long_cnt_d   = long_cnt_q;
    proto_cnt_d  = proto_cnt_q;
    complete     = 1'b0;
    proto_evt    = 1'b0;

    if (accept) begin
      if (rx_sop && state_q == IN_FRAME) proto_evt = 1'b1;
      if (!rx_sop && state_q == IDLE) begin
        proto_evt = 1'b1;
      end else if (rx_eop) begin
        complete = 1'b1;
        state_d  = IDLE;
        len_d    = 16'd0;
      end else begin
        state_d = IN_FRAME;
        len_d   = new_len;
      end
    end

    if (complete) begin
      frame_done_d = 1'b1;
      last_len_d   = new_len;
      frame_cnt_d  = sat_add(frame_cnt_q, 32'd1);
      byte_cnt_d   = sat_add(byte_cnt_q, {16'd0, new_len});
      if (rx_err != 6'd0)            err_cnt_d  = sat_add(err_cnt_q, 32'd1);
      if ({1'b0, new_len} < MIN_L)   runt_cnt_d = sat_add(runt_cnt_q, 32'd1);
      if ({1'b0, new_len} > MAX_L)   long_cnt_d = sat_add(long_cnt_q, 32'd1);
    end
    if (proto_evt) proto_cnt_d = sat_add(proto_cnt_q, 32'd1);

    // Clear overrides any same-cycle update; FSM and length are left alone.
    if (clr_stats) begin
      last_len_d  = 16'd0;
      frame_cnt_d = 32'd0;
      byte_cnt_d  = 32'd0;
      err_cnt_d   = 32'd0;
      runt_cnt_d  = 32'd0;
      long_cnt_d  = 32'd0;
      proto_cnt_d = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rx_ready_q   <= 1'b0;
      frame_done_q <= 1'b0;
      len_q        <= 16'd0;
      last_len_q   <= 16'd0;
      frame_cnt_q  <= 32'd0;
      byte_cnt_q   <= 32'd0;
      err_cnt_q    <= 32'd0;
      runt_cnt_q   <= 32'd0;
      long_cnt_q   <= 32'd0;
      proto_cnt_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      rx_ready_q   <= rx_ready_d;
      frame_done_q <= frame_done_d;
      len_q        <= len_d;
      last_len_q   <= last_len_d;
      frame_cnt_q  <= frame_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      err_cnt_q    <= err_cnt_d;
      runt_cnt_q   <= runt_cnt_d;
      long_cnt_q   <= long_cnt_d;
      proto_cnt_q  <= proto_cnt_d;
    end
  end

`ifdef FYP_RX_SEQ_CHECK_EN
  logic [2:0]  beat_idx_q, beat_idx_d;
  logic        seq_have_q, seq_have_d;
  logic [31:0] seq_cap_q, seq_cap_d;
  logic        seq_sync_q, seq_sync_d;
  logic [31:0] seq_exp_q, seq_exp_d;
  logic [31:0] seq_err_cnt_q, seq_err_cnt_d;
  logic        seq_beat;
  logic        frame_has_seq;
  logic [31:0] frame_seq;

  assign seq_beat = accept && state_q == IN_FRAME && !rx_sop && beat_idx_q == 3'd4;

  // beat_idx_q holds the index of the next beat and parks at 5 once past the sequence beat.
  always_comb begin
    beat_idx_d    = beat_idx_q;
    seq_have_d    = seq_have_q;
    seq_cap_d     = seq_cap_q;
    seq_sync_d    = seq_sync_q;
    seq_exp_d     = seq_exp_q;
    seq_err_cnt_d = seq_err_cnt_q;

    if (accept && (rx_sop || state_q == IN_FRAME)) begin
      if (rx_sop) begin
        beat_idx_d = 3'd1;
        seq_have_d = 1'b0;
      end else if (beat_idx_q != 3'd5) begin
        beat_idx_d = beat_idx_q + 3'd1;
      end
      if (seq_beat) begin
        seq_have_d = 1'b1;
        seq_cap_d  = rx_data;
      end
    end

    frame_has_seq = seq_beat || (seq_have_q && !rx_sop);
    frame_seq     = seq_beat ? rx_data : seq_cap_q;

    if (complete) begin
      seq_have_d = 1'b0;
      beat_idx_d = 3'd0;
      if (frame_has_seq) begin
        seq_exp_d  = frame_seq + 32'd1;
        seq_sync_d = 1'b1;
        if (seq_sync_q && frame_seq != seq_exp_q)
          seq_err_cnt_d = sat_add(seq_err_cnt_q, 32'd1);
      end
    end

    if (clr_stats) begin
      seq_sync_d    = 1'b0;
      seq_err_cnt_d = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_idx_q    <= 3'd0;
      seq_have_q    <= 1'b0;
      seq_cap_q     <= 32'd0;
      seq_sync_q    <= 1'b0;
      seq_exp_q     <= 32'd0;
      seq_err_cnt_q <= 32'd0;
    end else begin
      beat_idx_q    <= beat_idx_d;
      seq_have_q    <= seq_have_d;
      seq_cap_q     <= seq_cap_d;
      seq_sync_q    <= seq_sync_d;
      seq_exp_q     <= seq_exp_d;
      seq_err_cnt_q <= seq_err_cnt_d;
    end
  end

  assign seq_err_cnt = seq_err_cnt_q;
`else
  logic unused_data;
  assign unused_data = ^rx_data;
  assign seq_err_cnt = 32'd0;
`endif

  assign rx_ready   = rx_ready_q;
  assign frame_done = frame_done_q;
  assign last_len   = last_len_q;
  assign frame_cnt  = frame_cnt_q;
  assign byte_cnt   = byte_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign runt_cnt   = runt_cnt_q;
  assign long_cnt   = long_cnt_q;
  assign proto_cnt  = proto_cnt_q;

endmodule

// File: tb/tb_fyp_rx_monitor.sv
// Scoreboard testbench for fyp_rx_monitor: directed frames with hand-computed statistics.
`timescale 1ns/1ps
module tb_fyp_rx_monitor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] rx_data = 32'd0;
  logic        rx_valid = 1'b0;
  logic        rx_sop = 1'b0;
  logic        rx_eop = 1'b0;
  logic [1:0]  rx_empty = 2'd0;
  logic [5:0]  rx_err = 6'd0;
  logic        rx_ready;
  logic        clr_stats = 1'b0;
  logic        frame_done;
  logic [15:0] last_len;
  logic [31:0] frame_cnt, byte_cnt, err_cnt, runt_cnt, long_cnt, proto_cnt, seq_err_cnt;

`ifdef FYP_RX_SEQ_CHECK_EN
  localparam logic [31:0] SEQ_ON = 32'd1;
`else
  localparam logic [31:0] SEQ_ON = 32'd0;
`endif

  typedef struct {
    logic [15:0] len;
    logic [31:0] frames, bytes, errs, runts, longs, protos, seqerrs;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   compared = 0;
  int   mismatched = 0;
  int   cycleCnt = 0;
  int   eopCycle = 0;

  fyp_rx_monitor #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_empty(rx_empty), .rx_err(rx_err),
    .rx_ready(rx_ready), .clr_stats(clr_stats), .frame_done(frame_done),
    .last_len(last_len), .frame_cnt(frame_cnt), .byte_cnt(byte_cnt),
    .err_cnt(err_cnt), .runt_cnt(runt_cnt), .long_cnt(long_cnt),
    .proto_cnt(proto_cnt), .seq_err_cnt(seq_err_cnt)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cycleCnt++;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic exp_t mkExp(input logic [15:0] len, input logic [31:0] frames, input logic [31:0] bytes,
                                 input logic [31:0] errs, input logic [31:0] runts, input logic [31:0] longs,
                                 input logic [31:0] protos, input logic [31:0] seqerrs);
    exp_t e;
    e.len = len; e.frames = frames; e.bytes = bytes; e.errs = errs;
    e.runts = runts; e.longs = longs; e.protos = protos; e.seqerrs = seqerrs;
    return e;
  endfunction

  // Monitor: every frame_done pops one expectation; counters are sampled on the falling edge.
  always @(negedge clk) begin
    if (reset_n && frame_done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected frame_done", 32'd1, 32'd0);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("done latency", cycleCnt, eopCycle);
        checkOutput("last_len", {16'd0, last_len}, {16'd0, monExp.len});
        checkOutput("frame_cnt", frame_cnt, monExp.frames);
        checkOutput("byte_cnt", byte_cnt, monExp.bytes);
        checkOutput("err_cnt", err_cnt, monExp.errs);
        checkOutput("runt_cnt", runt_cnt, monExp.runts);
        checkOutput("long_cnt", long_cnt, monExp.longs);
        checkOutput("proto_cnt", proto_cnt, monExp.protos);
        checkOutput("seq_err_cnt", seq_err_cnt, monExp.seqerrs);
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic sendBeat(input logic sop, input logic eop, input logic [1:0] empty,
                          input logic [5:0] err, input logic [31:0] data, input logic clr);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_sop = sop; rx_eop = eop; rx_empty = empty;
    rx_err = err; rx_data = data; clr_stats = clr;
    if (eop) eopCycle = cycleCnt + 1;
  endtask

  task automatic idleBus();
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_empty = 2'd0;
    rx_err = 6'd0; clr_stats = 1'b0;
  endtask

  task automatic clearStats();
    @(posedge clk); #1;
    rx_valid = 1'b0; clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
  endtask

  // Beat 4 carries the sequence number; other beats carry their index.
  task automatic applyStimulus(input int nbytes, input logic [5:0] err, input logic [31:0] seq,
                               input logic clrOnEop, input exp_t e);
    int beats;
    logic [1:0] empty;
    beats = (nbytes + 3) / 4;
    empty = 2'(beats * 4 - nbytes);
    expQ.push_back(e);
    for (int i = 0; i < beats; i++) begin
      if (i == beats - 1)
        sendBeat(i == 0, 1'b1, empty, err, (i == 4) ? seq : 32'(i), clrOnEop);
      else
        sendBeat(i == 0, 1'b0, 2'd0, 6'd0, (i == 4) ? seq : 32'(i), 1'b0);
    end
    idleBus();
    waitCycles(3);
  endtask

  initial begin
    waitCycles(2);
    #1;
    checkOutput("reset rx_ready", {31'd0, rx_ready}, 32'd0);
    checkOutput("reset frame_done", {31'd0, frame_done}, 32'd0);
    checkOutput("reset last_len", {16'd0, last_len}, 32'd0);
    checkOutput("reset frame_cnt", frame_cnt, 32'd0);
    reset_n = 1'b1;
    waitCycles(2);
    #1;
    checkOutput("rx_ready after reset", {31'd0, rx_ready}, 32'd1);

    $display("[TB] basic 64-byte frame");
    applyStimulus(64, 6'd0, 32'd10, 1'b0, mkExp(16'd64, 1, 64, 0, 0, 0, 0, 0));

    $display("[TB] runt and long frames");
    clearStats();
    applyStimulus(61, 6'd0, 32'd100, 1'b0, mkExp(16'd61, 1, 61, 0, 1, 0, 0, 0));
    applyStimulus(1520, 6'd0, 32'd101, 1'b0, mkExp(16'd1520, 2, 1581, 0, 1, 1, 0, 0));

    $display("[TB] sop mid-frame and stray beat");
    clearStats();
    for (int i = 0; i < 5; i++) sendBeat(i == 0, 1'b0, 2'd0, 6'd0, 32'd77, 1'b0);
    applyStimulus(64, 6'd0, 32'd50, 1'b0, mkExp(16'd64, 1, 64, 0, 0, 0, 1, 0));
    sendBeat(1'b0, 1'b0, 2'd0, 6'd0, 32'hDEAD_BEEF, 1'b0);
    idleBus();
    waitCycles(2);
    #1;
    checkOutput("stray proto_cnt", proto_cnt, 32'd2);
    checkOutput("stray frame_cnt", frame_cnt, 32'd1);

    $display("[TB] error frame with coincident clear");
    clearStats();
    applyStimulus(64, 6'h02, 32'd0, 1'b1, mkExp(16'd0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("clr err_cnt", err_cnt, 32'd0);
    checkOutput("clr frame_cnt", frame_cnt, 32'd0);
    checkOutput("clr byte_cnt", byte_cnt, 32'd0);
    applyStimulus(64, 6'd0, 32'd0, 1'b0, mkExp(16'd64, 1, 64, 0, 0, 0, 0, 0));

    $display("[TB] sequence 10 11 13 14");
    clearStats();
    applyStimulus(64, 6'd0, 32'd10, 1'b0, mkExp(16'd64, 1, 64, 0, 0, 0, 0, 0));
    applyStimulus(64, 6'd0, 32'd11, 1'b0, mkExp(16'd64, 2, 128, 0, 0, 0, 0, 0));
    applyStimulus(64, 6'd0, 32'd13, 1'b0, mkExp(16'd64, 3, 192, 0, 0, 0, 0, SEQ_ON));
    applyStimulus(64, 6'd0, 32'd14, 1'b0, mkExp(16'd64, 4, 256, 0, 0, 0, 0, SEQ_ON));

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 5; i++) sendBeat(i == 0, 1'b0, 2'd0, 6'd0, 32'd5, 1'b0);
    @(posedge clk); #3;
    reset_n = 1'b0;
    rx_valid = 1'b0; rx_sop = 1'b0;
    #1;
    checkOutput("mid reset rx_ready", {31'd0, rx_ready}, 32'd0);
    checkOutput("mid reset frame_cnt", frame_cnt, 32'd0);
    checkOutput("mid reset byte_cnt", byte_cnt, 32'd0);
    checkOutput("mid reset last_len", {16'd0, last_len}, 32'd0);
    waitCycles(2);
    #1;
    reset_n = 1'b1;
    waitCycles(2);
    #1;
    checkOutput("rx_ready after mid reset", {31'd0, rx_ready}, 32'd1);
    applyStimulus(64, 6'd0, 32'd200, 1'b0, mkExp(16'd64, 1, 64, 0, 0, 0, 0, 0));

    $display("[TB] length saturation");
    applyStimulus(65540, 6'd0, 32'd201, 1'b0, mkExp(16'hFFFF, 2, 65599, 0, 0, 1, 0, 0));

    waitCycles(4);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fyp_rx_monitor.md
FYP_RX_MONITOR -- requirements
Module: fyp_rx_monitor

Interface
REQ-001 Parameter MIN_LEN, default 64, minimum legal frame length in bytes as delivered on Avalon-ST.
REQ-002 Parameter MAX_LEN, default 1518, maximum legal frame length in bytes.
REQ-003 Port clk  input  1  single 125 MHz clock; all logic on rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port rx_data  input  32  Avalon-ST receive data from MAC; first byte in bits [31:24].
REQ-006 Port rx_valid  input  1  beat valid.
REQ-007 Port rx_sop  input  1  start of packet.
REQ-008 Port rx_eop  input  1  end of packet.
REQ-009 Port rx_empty  input  2  unused bytes on the eop beat.
REQ-010 Port rx_err  input  6  MAC error flags, valid on the eop beat.
REQ-011 Port rx_ready  output  1  sink ready.
REQ-012 Port clr_stats  input  1  synchronous clear of all statistics.
REQ-013 Port frame_done  output  1  one-cycle pulse per completed frame.
REQ-014 Port last_len  output  16  length in bytes of the last completed frame.
REQ-015 Ports frame_cnt, byte_cnt, err_cnt, runt_cnt, long_cnt, proto_cnt, seq_err_cnt  output  32 each  statistics counters.

Function
REQ-016 A beat SHALL be accepted when rx_valid and rx_ready are both high; rx_ready SHALL be high from the first clk edge after reset release, and the block SHALL never stall.
REQ-017 The FSM SHALL have states IDLE and IN_FRAME.
- IDLE: accepted sop without eop -> IN_FRAME; accepted sop with eop -> completes a single-beat frame and stays in IDLE.
- IDLE: accepted beat without sop -> discarded, proto_cnt +1.
- IN_FRAME: accepted eop -> frame completes -> IDLE.
- IN_FRAME: accepted sop -> current frame abandoned (not counted in frame_cnt), proto_cnt +1, new frame starts; if that beat also has eop, the new frame completes.
REQ-018 Frame length SHALL equal 4 bytes per non-eop beat plus (4 - rx_empty) on the eop beat, and SHALL saturate at 16'hFFFF.
REQ-019 On completion, the block SHALL update counters, pulse frame_done and load last_len one cycle after the eop beat is accepted.
REQ-020 On completion: frame_cnt +1; byte_cnt + length; err_cnt +1 if rx_err is nonzero; runt_cnt +1 if length < MIN_LEN; long_cnt +1 if length > MAX_LEN.
REQ-021 All counters SHALL saturate at 32'hFFFFFFFF.
REQ-022 clr_stats SHALL zero all counters and last_len on the next edge.
REQ-023 If clr_stats coincides with a completion update, clear SHALL win, and that frame SHALL not be counted.
REQ-024 clr_stats SHALL not affect FSM state or the in-progress length count.

Reset
REQ-025 Assertion of reset_n SHALL immediately force the following, regardless of any frame in progress; the abandoned frame SHALL not be counted:
- state IDLE;
- rx_ready 0;
- frame_done 0;
- last_len 0;
- all counters 0;
- length accumulator 0;
- sequence tracker unsynchronised.

Configuration
REQ-026 Macro FYP_RX_SEQ_CHECK_EN enables sequence checking: the block SHALL take a 32-bit sequence number from rx_data on beat index 4 of each frame (bytes 16-19, counting the sop beat as 0).
- For the first frame carrying beat 4 after reset or clr_stats, the block SHALL load expected = seq+1 and SHALL not flag an error.
- On a subsequent mismatch, seq_err_cnt SHALL increment and expected SHALL resync to seq+1.
- Frames with fewer than 5 beats and abandoned frames SHALL be skipped.
REQ-027 Without FYP_RX_SEQ_CHECK_EN, seq_err_cnt SHALL be constant 0 and no sequence logic SHALL be synthesised.

Verification
REQ-028 Reset release, then one 64-byte frame (16 beats, empty=0, err=0) -> frame_done one cycle after eop, frame_cnt=1, byte_cnt=64, last_len=64, runt/long/err=0.
REQ-029 A 61-byte frame (eop empty=3) followed by a 1520-byte frame -> runt_cnt=1, long_cnt=1, byte_cnt=1581.
REQ-030 sop mid-frame after 5 beats, then the new frame is terminated at 64 bytes -> proto_cnt=1, frame_cnt=1, byte_cnt=64; a stray valid beat in IDLE -> proto_cnt=2.
REQ-031 A frame with rx_err=6'h02 on eop, with clr_stats asserted on the completion cycle -> all counters 0 afterwards; the next clean frame gives frame_cnt=1, err_cnt=0.
REQ-032 With FYP_RX_SEQ_CHECK_EN: frames with seq 10, 11, 13, 14 -> seq_err_cnt=1; without the macro -> seq_err_cnt=0.
REQ-033 reset_n asserted mid-frame, then released, then one 64-byte frame -> frame_cnt=1, proto_cnt=0, rx_ready low during reset.
